// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer.
//   - opcode constants for the supported instruction classes
//   - 4-bit state encodings (values are visible on state_o for debug)
//   - encodings of the datapath selects: ALU operation, PC source, ALU B operand
//   - the bundle of datapath control strobes driven by the sequencer
package multicycle_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_ADDI_EXEC = 4'd11,
    ST_ADDI_WB   = 4'd12,
    ST_TRAP      = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,
    PC_SRC_ALUOUT = 2'b01,
    PC_SRC_JUMP   = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    SRC_B_REG     = 2'b00,
    SRC_B_FOUR    = 2'b01,
    SRC_B_IMM     = 2'b10,
    SRC_B_IMM_SH2 = 2'b11
  } alu_src_b_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    pc_src_t    pc_src;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // States that hold a request to the shared memory and wait on its ready.
  function automatic logic is_mem_wait(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on the shared memory.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   clear    : force the count to zero (takes priority over enable)
//   enable   : count one more wait cycle
//   timeout  : count has reached MEM_TIMEOUT
// The count saturates at MEM_TIMEOUT so timeout stays asserted until cleared.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

  logic [7:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples values from before the edge regardless of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 8'd1;
    end
  end

  assign timeout = (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS datapath. Steps each instruction through
// fetch / decode / execute / memory / writeback, handshakes with a
// variable-latency shared memory, counts retired instructions and traps on an
// illegal opcode or a memory timeout.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   start_i                 : run enable, sampled in IDLE and at retire
//   op_i                    : IR[31:26], valid from DECODE onward
//   zero_i                  : ALU zero flag (branch decision)
//   mem_ready_i             : memory completes the current request this cycle
//   mem_read_o/mem_write_o  : memory request strobes
//   i_or_d_o                : memory address select (0 PC, 1 ALUOut)
//   ir_write_o, pc_write_o  : instruction register / PC load enables
//   pc_src_o                : PC source select
//   alu_src_a_o/alu_src_b_o : ALU operand selects
//   alu_op_o                : operation class to ALU_Control
//   reg_dst_o, mem_to_reg_o : register write address / data selects
//   reg_write_o             : register file write enable
//   state_o, busy_o, err_o  : debug state, activity, sticky trap flag
//   retired_o               : retired-instruction count (wraps)
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             i_or_d_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic [1:0]       pc_src_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic [3:0]       state_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] retired_o
);

  state_t           state_q, state_d;
  ctrl_t            ctrl;
  logic             retire;
  logic             err_q;
  logic [CNT_W-1:0] retired_q;

  logic in_wait;
  logic timer_clear;
  logic timer_enable;
  logic timer_timeout;

  // The timer sits at zero outside the wait states and is cleared as a request
  // completes, so every FETCH / MEM_READ / MEM_WRITE visit starts from zero.
  assign in_wait      = is_mem_wait(state_q);
  assign timer_clear  = !in_wait || mem_ready_i;
  assign timer_enable = in_wait && !mem_ready_i;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .timeout (timer_timeout)
  );

  // NOTE: every signal written here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    retire  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_SRC_ALU;
        if (mem_ready_i) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = ST_DECODE;
        end else if (timer_timeout) begin
          state_d = ST_TRAP;
        end
      end

      ST_DECODE: begin
        // ALU forms the branch target PC + (imm << 2) speculatively.
        ctrl.alu_src_b = SRC_B_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
        case (op_i)
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_R:         state_d = ST_R_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDI_EXEC;
          default:      state_d = ST_TRAP;
        endcase
      end

      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_d        = (op_i == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      end

      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (mem_ready_i)        state_d = ST_MEM_WB;
        else if (timer_timeout) state_d = ST_TRAP;
      end

      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        retire          = 1'b1;
      end

      ST_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (mem_ready_i)        retire  = 1'b1;
        else if (timer_timeout) state_d = ST_TRAP;
      end

      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_FUNCT;
        state_d        = ST_R_WB;
      end

      ST_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        retire         = 1'b1;
      end

      ST_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_d        = ST_ADDI_WB;
      end

      ST_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
      end

      ST_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_SRC_ALUOUT;
        ctrl.pc_write  = zero_i;
        retire         = 1'b1;
      end

      ST_JUMP: begin
        ctrl.pc_src   = PC_SRC_JUMP;
        ctrl.pc_write = 1'b1;
        retire        = 1'b1;
      end

      ST_TRAP: begin
        state_d = ST_TRAP;
      end

      // Unused encodings are treated as a corrupted sequencer.
      default: state_d = ST_TRAP;
    endcase

    // start_i is only looked at when an instruction completes.
    if (retire) state_d = start_i ? ST_FETCH : ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_TRAP) err_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign mem_read_o   = ctrl.mem_read;
  assign mem_write_o  = ctrl.mem_write;
  assign i_or_d_o     = ctrl.i_or_d;
  assign ir_write_o   = ctrl.ir_write;
  assign pc_write_o   = ctrl.pc_write;
  assign pc_src_o     = ctrl.pc_src;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign alu_op_o     = ctrl.alu_op;
  assign reg_dst_o    = ctrl.reg_dst;
  assign mem_to_reg_o = ctrl.mem_to_reg;
  assign reg_write_o  = ctrl.reg_write;

  assign state_o   = state_q;
  assign busy_o    = (state_q != ST_IDLE) && (state_q != ST_TRAP);
  assign err_o     = err_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Each test pushes one scoreboard
// entry per clock cycle (inputs to drive during that cycle plus the expected
// state, retired count and {reg_write, ir_write, pc_write}); drain tasks pop
// the entries, drive the inputs and compare at the following falling edge.
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

  localparam int unsigned CNT_W       = 32;
  localparam int unsigned MEM_TIMEOUT = 4;
  localparam logic [5:0]  OP_ILLEGAL  = 6'b111111;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic [5:0]       op_i = '0;
  logic             zero_i = 1'b0;
  logic             mem_ready_i = 1'b0;
  logic             mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o;
  logic [1:0]       pc_src_o, alu_src_b_o, alu_op_o;
  logic             alu_src_a_o, reg_dst_o, mem_to_reg_o, reg_write_o;
  logic [3:0]       state_o;
  logic             busy_o, err_o;
  logic [CNT_W-1:0] retired_o;

  multicycle_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .op_i         (op_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .i_or_d_o     (i_or_d_o),
    .ir_write_o   (ir_write_o),
    .pc_write_o   (pc_write_o),
    .pc_src_o     (pc_src_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .reg_write_o  (reg_write_o),
    .state_o      (state_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .retired_o    (retired_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic             start;
    logic             ready;
    logic             zero;
    logic [5:0]       op;
    logic [3:0]       st;
    logic [CNT_W-1:0] ret;
    logic [2:0]       strb;  // {reg_write, ir_write, pc_write}
  } step_t;

  step_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic void push(input logic [3:0] st, input int unsigned ret,
                               input logic [2:0] strb, input logic s,
                               input logic r, input logic z, input logic [5:0] op);
    step_t e;
    e.start = s;
    e.ready = r;
    e.zero  = z;
    e.op    = op;
    e.st    = st;
    e.ret   = CNT_W'(ret);
    e.strb  = strb;
    exp_q.push_back(e);
  endfunction

  task automatic drain_all(input string name);
    step_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge clk_i);
      #1;
      start_i     = e.start;
      mem_ready_i = e.ready;
      zero_i      = e.zero;
      op_i        = e.op;
      @(negedge clk_i);
      checks++;
      if (state_o !== e.st) begin
        errors++;
        $display("FAIL %s state: got %0d expected %0d", name, state_o, e.st);
      end
      checks++;
      if (retired_o !== e.ret) begin
        errors++;
        $display("FAIL %s retired: got %0d expected %0d", name, retired_o, e.ret);
      end
      checks++;
      if ({reg_write_o, ir_write_o, pc_write_o} !== e.strb) begin
        errors++;
        $display("FAIL %s strobes(rw,irw,pcw) in state %0d: got %b expected %b",
                 name, state_o, {reg_write_o, ir_write_o, pc_write_o}, e.strb);
      end
    end
  endtask

  // Applies reset for one edge from wherever the DUT is and checks the
  // post-reset outputs. Returns at the falling edge of the first reset cycle.
  task automatic do_reset(input string name);
    rst_i       = 1'b1;
    start_i     = 1'b0;
    mem_ready_i = 1'b0;
    zero_i      = 1'b0;
    op_i        = '0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (state_o !== 4'd0 || err_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s status: state=%0d err=%b busy=%b expected 0/0/0",
               name, state_o, err_o, busy_o);
    end
    checks++;
    if (retired_o !== '0) begin
      errors++;
      $display("FAIL %s retired: got %0d expected 0", name, retired_o);
    end
    checks++;
    if ({mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o, pc_src_o,
         alu_src_a_o, alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o,
         reg_write_o} !== 14'b0) begin
      errors++;
      $display("FAIL %s controls: got %b expected all zero", name,
               {mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o, pc_src_o,
                alu_src_a_o, alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o,
                reg_write_o});
    end
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_r_type();
    do_reset("r_type_reset");
    push(ST_IDLE,   0, 3'b000, 1, 1, 0, OP_R);
    push(ST_FETCH,  0, 3'b011, 1, 1, 0, OP_R);
    push(ST_DECODE, 0, 3'b000, 1, 1, 0, OP_R);
    push(ST_R_EXEC, 0, 3'b000, 1, 1, 0, OP_R);
    drain_all("r_type");
    checks++;
    if ({alu_src_a_o, alu_src_b_o, alu_op_o} !== 5'b1_00_10) begin
      errors++;
      $display("FAIL r_exec selects: got %b expected 10010",
               {alu_src_a_o, alu_src_b_o, alu_op_o});
    end
    push(ST_R_WB, 0, 3'b100, 1, 1, 0, OP_R);
    drain_all("r_type");
    checks++;
    if (reg_dst_o !== 1'b1 || mem_to_reg_o !== 1'b0) begin
      errors++;
      $display("FAIL r_wb selects: reg_dst=%b mem_to_reg=%b expected 1/0",
               reg_dst_o, mem_to_reg_o);
    end
    push(ST_FETCH, 1, 3'b011, 1, 1, 0, OP_R);
    drain_all("r_type");
  endtask

  task automatic test_lw_wait();
    do_reset("lw_reset");
    push(ST_IDLE, 0, 3'b000, 1, 0, 0, OP_LW);
    repeat (3) push(ST_FETCH, 0, 3'b000, 1, 0, 0, OP_LW);
    push(ST_FETCH,    0, 3'b011, 1, 1, 0, OP_LW);
    push(ST_DECODE,   0, 3'b000, 1, 0, 0, OP_LW);
    push(ST_MEM_ADDR, 0, 3'b000, 1, 0, 0, OP_LW);
    repeat (2) push(ST_MEM_READ, 0, 3'b000, 1, 0, 0, OP_LW);
    push(ST_MEM_READ, 0, 3'b000, 1, 1, 0, OP_LW);
    drain_all("lw");
    checks++;
    if (mem_read_o !== 1'b1 || i_or_d_o !== 1'b1) begin
      errors++;
      $display("FAIL lw mem_read: mem_read=%b i_or_d=%b expected 1/1",
               mem_read_o, i_or_d_o);
    end
    push(ST_MEM_WB, 0, 3'b100, 0, 0, 0, OP_LW);
    drain_all("lw");
    checks++;
    if (mem_to_reg_o !== 1'b1 || reg_dst_o !== 1'b0) begin
      errors++;
      $display("FAIL lw mem_wb: mem_to_reg=%b reg_dst=%b expected 1/0",
               mem_to_reg_o, reg_dst_o);
    end
    push(ST_IDLE, 1, 3'b000, 0, 0, 0, OP_LW);
    drain_all("lw");
  endtask

  task automatic test_beq();
    do_reset("beq_reset");
    push(ST_IDLE,   0, 3'b000, 1, 1, 0, OP_BEQ);
    push(ST_FETCH,  0, 3'b011, 1, 1, 0, OP_BEQ);
    push(ST_DECODE, 0, 3'b000, 1, 1, 0, OP_BEQ);
    push(ST_BRANCH, 0, 3'b000, 1, 1, 0, OP_BEQ);
    drain_all("beq_not_taken");
    checks++;
    if (pc_src_o !== 2'b01 || alu_op_o !== 2'b01) begin
      errors++;
      $display("FAIL beq selects: pc_src=%b alu_op=%b expected 01/01", pc_src_o, alu_op_o);
    end
    push(ST_FETCH,  1, 3'b011, 1, 1, 1, OP_BEQ);
    push(ST_DECODE, 1, 3'b000, 1, 1, 1, OP_BEQ);
    push(ST_BRANCH, 1, 3'b001, 0, 1, 1, OP_BEQ);
    drain_all("beq_taken");
    checks++;
    if (pc_src_o !== 2'b01) begin
      errors++;
      $display("FAIL beq taken pc_src: got %b expected 01", pc_src_o);
    end
    push(ST_IDLE, 2, 3'b000, 0, 1, 1, OP_BEQ);
    drain_all("beq_retire");
  endtask

  task automatic test_illegal();
    do_reset("illegal_reset");
    push(ST_IDLE,   0, 3'b000, 1, 1, 0, OP_ILLEGAL);
    push(ST_FETCH,  0, 3'b011, 1, 1, 0, OP_ILLEGAL);
    push(ST_DECODE, 0, 3'b000, 1, 1, 0, OP_ILLEGAL);
    push(ST_TRAP,   0, 3'b000, 1, 1, 0, OP_ILLEGAL);
    drain_all("illegal");
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL illegal trap: err=%b busy=%b expected 1/0", err_o, busy_o);
    end
    repeat (20) push(ST_TRAP, 0, 3'b000, 1, 1, 1, OP_ILLEGAL);
    drain_all("trap_hold");
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL trap_hold err: got %b expected 1", err_o);
    end
    do_reset("trap_exit_reset");
  endtask

  task automatic test_timeout();
    do_reset("timeout_reset");
    push(ST_IDLE, 0, 3'b000, 1, 0, 0, OP_R);
    repeat (5) push(ST_FETCH, 0, 3'b000, 1, 0, 0, OP_R);
    push(ST_TRAP, 0, 3'b000, 1, 0, 0, OP_R);
    drain_all("timeout");
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout err: got %b expected 1", err_o);
    end
    // Ready arrives in the very cycle the timer reaches the limit: ready wins.
    do_reset("timeout_tie_reset");
    push(ST_IDLE, 0, 3'b000, 1, 0, 0, OP_R);
    repeat (4) push(ST_FETCH, 0, 3'b000, 1, 0, 0, OP_R);
    push(ST_FETCH,  0, 3'b011, 1, 1, 0, OP_R);
    push(ST_DECODE, 0, 3'b000, 1, 1, 0, OP_R);
    drain_all("timeout_tie");
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_tie err: got %b expected 0", err_o);
    end
  endtask

  task automatic test_start_drop();
    do_reset("start_drop_reset");
    push(ST_IDLE,   0, 3'b000, 1, 1, 0, OP_R);
    push(ST_FETCH,  0, 3'b011, 1, 1, 0, OP_R);
    push(ST_DECODE, 0, 3'b000, 1, 1, 0, OP_R);
    push(ST_R_EXEC, 0, 3'b000, 0, 1, 0, OP_R);
    push(ST_R_WB,   0, 3'b100, 0, 1, 0, OP_R);
    push(ST_IDLE,   1, 3'b000, 0, 1, 0, OP_R);
    push(ST_IDLE,   1, 3'b000, 0, 1, 0, OP_R);
    drain_all("start_drop");
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL start_drop busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset("b2b_reset");
    push(ST_IDLE,      0, 3'b000, 1, 1, 0, OP_SW);
    push(ST_FETCH,     0, 3'b011, 1, 1, 0, OP_SW);
    push(ST_DECODE,    0, 3'b000, 1, 1, 0, OP_SW);
    push(ST_MEM_ADDR,  0, 3'b000, 1, 1, 0, OP_SW);
    push(ST_MEM_WRITE, 0, 3'b000, 1, 1, 0, OP_SW);
    drain_all("b2b_sw");
    checks++;
    if (mem_write_o !== 1'b1 || i_or_d_o !== 1'b1 || mem_read_o !== 1'b0) begin
      errors++;
      $display("FAIL sw mem_write: mem_write=%b i_or_d=%b mem_read=%b expected 1/1/0",
               mem_write_o, i_or_d_o, mem_read_o);
    end
    push(ST_FETCH,     1, 3'b011, 1, 1, 0, OP_ADDI);
    push(ST_DECODE,    1, 3'b000, 1, 1, 0, OP_ADDI);
    push(ST_ADDI_EXEC, 1, 3'b000, 1, 1, 0, OP_ADDI);
    push(ST_ADDI_WB,   1, 3'b100, 1, 1, 0, OP_ADDI);
    drain_all("b2b_addi");
    checks++;
    if (reg_dst_o !== 1'b0 || mem_to_reg_o !== 1'b0) begin
      errors++;
      $display("FAIL addi_wb selects: reg_dst=%b mem_to_reg=%b expected 0/0",
               reg_dst_o, mem_to_reg_o);
    end
    push(ST_FETCH,  2, 3'b011, 1, 1, 0, OP_J);
    push(ST_DECODE, 2, 3'b000, 1, 1, 0, OP_J);
    push(ST_JUMP,   2, 3'b001, 0, 1, 0, OP_J);
    drain_all("b2b_j");
    checks++;
    if (pc_src_o !== 2'b10) begin
      errors++;
      $display("FAIL jump pc_src: got %b expected 10", pc_src_o);
    end
    push(ST_IDLE, 3, 3'b000, 0, 1, 0, OP_J);
    drain_all("b2b_retire");
  endtask

  // Continues from the back-to-back run so the counter is non-zero before
  // reset hits in the middle of a memory read.
  task automatic test_reset_mid_read();
    push(ST_IDLE,     3, 3'b000, 1, 1, 0, OP_LW);
    push(ST_FETCH,    3, 3'b011, 1, 1, 0, OP_LW);
    push(ST_DECODE,   3, 3'b000, 1, 1, 0, OP_LW);
    push(ST_MEM_ADDR, 3, 3'b000, 1, 1, 0, OP_LW);
    push(ST_MEM_READ, 3, 3'b000, 1, 0, 0, OP_LW);
    drain_all("mid_read");
    do_reset("mid_read_reset");
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_timeout();
    test_start_drop();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS datapath (PC, Instruction_Memory, Registers, ALU, ALU_Control, MUXes); replaces single-cycle Control.
- Steps each instruction through fetch/decode/execute/memory/writeback states and handshakes with a shared variable-latency memory.
- Drives all datapath enables and mux selects.
- Counts retired instructions and traps on illegal opcodes or memory timeout.

Parameters:
- MEM_TIMEOUT, 16, max cycles to wait for mem_ready_i in any memory state before trapping (range 1..255).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  run enable; level-sensitive.
- op_i  in  6  opcode, IR[31:26], valid from DECODE onward.
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory completes current request this cycle.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- i_or_d_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write_o  out  1  latch instruction register.
- pc_write_o  out  1  PC update enable.
- pc_src_o  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
- alu_src_a_o  out  1  ALU A: 0 = PC, 1 = register A.
- alu_src_b_o  out  2  ALU B: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_op_o  out  2  to ALU_Control: 00 add, 01 sub, 10 funct-decoded.
- reg_dst_o  out  1  write address: 0 = rt, 1 = rd.
- mem_to_reg_o  out  1  write data: 0 = ALUOut, 1 = MDR.
- reg_write_o  out  1  register file write enable.
- state_o  out  4  current state encoding, for debug.
- busy_o  out  1  high in any state except IDLE and TRAP.
- err_o  out  1  sticky trap flag.
- retired_o  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (rst_i = 1 at an edge): state = IDLE, err_o = 0, retired_o = 0, timer = 0.
  - All strobes and selects are 0 in IDLE; this holds on any cycle, including mid-instruction.
  - An in-flight memory request is abandoned.
- Opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, J = 000010, ADDI = 001000. Any other opcode is illegal.
- States and transitions:
  - IDLE: go to FETCH if start_i = 1.
  - FETCH (mem_read, i_or_d = 0, src_a = 0, src_b = 01, alu_op = 00, pc_src = 00): hold until mem_ready_i. In that cycle ir_write = 1 and pc_write = 1; then go to DECODE.
  - DECODE (src_a = 0, src_b = 11, alu_op = 00): computes branch target. Next state by op_i:
    - LW or SW -> MEM_ADDR
    - R -> R_EXEC
    - BEQ -> BRANCH
    - J -> JUMP
    - ADDI -> ADDI_EXEC
    - illegal -> TRAP
  - MEM_ADDR (src_a = 1, src_b = 10, alu_op = 00): go to MEM_READ for LW, MEM_WRITE for SW.
  - MEM_READ (mem_read, i_or_d = 1): hold until mem_ready_i, then go to MEM_WB.
  - MEM_WB (reg_write, reg_dst = 0, mem_to_reg = 1): retires.
  - MEM_WRITE (mem_write, i_or_d = 1): hold until mem_ready_i; retires in that cycle.
  - R_EXEC (src_a = 1, src_b = 00, alu_op = 10): go to R_WB.
  - R_WB (reg_write, reg_dst = 1, mem_to_reg = 0): retires.
  - ADDI_EXEC (src_a = 1, src_b = 10, alu_op = 00): go to ADDI_WB.
  - ADDI_WB (reg_write, reg_dst = 0, mem_to_reg = 0): retires.
  - BRANCH (src_a = 1, src_b = 00, alu_op = 01, pc_src = 01): pc_write = zero_i; retires.
  - JUMP (pc_src = 10, pc_write = 1): retires.
  - TRAP: err_o = 1, all strobes 0. Exit only by reset.
- Retire rules:
  - A retiring state increments retired_o by 1; it wraps modulo 2^CNT_W.
  - After retiring, go to FETCH if start_i = 1, else IDLE.
  - Deasserting start_i mid-instruction never aborts the instruction; it is only sampled at retire and in IDLE.
- Memory timer:
  - Cleared on entry to FETCH, MEM_READ or MEM_WRITE; increments each cycle mem_ready_i = 0 in those states.
  - If it reaches MEM_TIMEOUT with mem_ready_i still 0, go to TRAP.
  - If mem_ready_i = 1 arrives in the same cycle as the timeout, the ready wins.
- Moore outputs derive from state only, except pc_write and ir_write in FETCH, pc_write in BRANCH, and the retire increment in MEM_WRITE, which are qualified combinationally by mem_ready_i or zero_i.
- Latency with zero-wait memory: R/ADDI/LW-free paths:
  - R and ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ and J: 3 cycles.
  - Each memory wait cycle adds 1.

Decomposition:
- Package multicycle_pkg holds:
  - opcode constants;
  - 4-bit state encodings (IDLE = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_READ = 4, MEM_WB = 5, MEM_WRITE = 6, R_EXEC = 7, R_WB = 8, BRANCH = 9, JUMP = 10, ADDI_EXEC = 11, ADDI_WB = 12, TRAP = 15);
  - alu_op, pc_src and alu_src_b encodings.
- One sub-module, mem_wait_timer: clear/enable inputs, timeout output, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset, then start_i = 1, op_i = 000000, mem_ready_i = 1 constant:
  - state_o sequence is 0, 1, 2, 7, 8, 1.
  - reg_write_o = 1 with reg_dst_o = 1 only in state 8.
  - retired_o = 1 after 4 cycles.
- LW with mem_ready_i low for 3 cycles in FETCH and 2 in MEM_READ:
  - ir_write_o pulses once, on the ready cycle.
  - retire occurs 10 cycles after leaving IDLE.
  - mem_to_reg_o = 1 in MEM_WB.
- BEQ twice:
  - zero_i = 0 -> pc_write_o stays 0 in BRANCH.
  - zero_i = 1 -> pc_write_o = 1 with pc_src_o = 01.
  - retired_o increments both times.
- op_i = 111111 at DECODE:
  - next state is TRAP (15), err_o = 1, busy_o = 0.
  - state and err_o hold for 20 cycles until rst_i = 1 clears both.
- MEM_TIMEOUT = 4 with mem_ready_i stuck at 0 in FETCH:
  - TRAP on the 5th FETCH cycle.
  - Repeat with ready arriving on the 4th wait cycle -> DECODE, no trap.
- start_i dropped during R_EXEC:
  - instruction completes with retired_o +1, then IDLE with busy_o = 0.
  - rst_i asserted during MEM_READ -> next cycle state 0, all outputs 0, retired_o = 0.
